// File: rtl/cpu6502_pc_sequencer.sv
// cpu6502_pc_sequencer
// Owns the 6502 program counter and routes every PC update through the
// external jump calculator: +1 increments, absolute loads and the NMOS
// relative-branch timing (2 cycles not taken, 3 taken, 4 with page cross).
module cpu6502_pc_sequencer #(
    parameter logic [15:0] RESET_PC = 16'hFFFC
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ready,
    input  logic        i_pcIncrement,
    input  logic        i_jumpLoad,
    input  logic [15:0] i_jumpTarget,
    input  logic        i_branchStart,
    input  logic        i_branchTaken,
    input  logic [7:0]  i_branchOffset,
    input  logic [15:0] i_calcNewPC,
    output logic [15:0] o_pc,
    output logic        o_calcIncrement,
    output logic        o_calcJumpRelative,
    output logic        o_calcJumpAbsolute,
    output logic [15:0] o_calcAbsoluteAddress,
    output logic [7:0]  o_calcRelativeOffset,
    output logic        o_busy,
    output logic        o_branchDone
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BR_ADD = 2'd1;
    localparam logic [1:0] ST_BR_FIX = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [15:0] r_pc;
    logic [7:0]  r_offset;
    logic [15:0] r_target;
    logic        r_branch_done;

    logic [15:0] w_pc_next;
    logic [7:0]  w_offset_next;
    logic [15:0] w_target_next;
    logic        w_done_next;
    logic        w_same_page;

    // The branch target stays on the current page when the high bytes match;
    // a wrap through 0xFFFF/0x0000 changes the high byte and so counts as a cross.
    assign w_same_page = (i_calcNewPC[15:8] == r_pc[15:8]);

    // State register: reset wins, RDY low freezes the sequence.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else if (i_ready) begin
            r_state <= w_state_next;
        end else begin
            r_state <= r_state;
        end
    end

    // Next-state logic: only a taken branch leaves IDLE; a page cross adds BR_FIX.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!i_jumpLoad && i_branchStart && i_branchTaken) begin
                    w_state_next = ST_BR_ADD;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_BR_ADD: begin
                if (w_same_page) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_BR_FIX;
                end
            end
            ST_BR_FIX: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Output logic: drive exactly one calculator control and form the next PC/register values.
    always_comb begin
        o_calcIncrement       = 1'b0;
        o_calcJumpRelative    = 1'b0;
        o_calcJumpAbsolute    = 1'b0;
        o_calcAbsoluteAddress = 16'h0000;
        o_calcRelativeOffset  = 8'h00;
        w_pc_next             = r_pc;
        w_offset_next         = r_offset;
        w_target_next         = r_target;
        w_done_next           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_jumpLoad) begin
                    o_calcJumpAbsolute    = 1'b1;
                    o_calcAbsoluteAddress = i_jumpTarget;
                    w_pc_next             = i_calcNewPC;
                end else if (i_branchStart) begin
                    // Step past the offset byte; a not-taken branch ends here.
                    o_calcIncrement = 1'b1;
                    w_pc_next       = i_calcNewPC;
                    w_offset_next   = i_branchOffset;
                    w_done_next     = ~i_branchTaken;
                end else if (i_pcIncrement) begin
                    o_calcIncrement = 1'b1;
                    w_pc_next       = i_calcNewPC;
                end else begin
                    w_pc_next = r_pc;
                end
            end
            ST_BR_ADD: begin
                o_calcJumpRelative   = 1'b1;
                o_calcRelativeOffset = r_offset;
                if (w_same_page) begin
                    w_pc_next   = i_calcNewPC;
                    w_done_next = 1'b1;
                end else begin
                    // Dummy read on the old page, real target fixed up next cycle.
                    w_pc_next     = {r_pc[15:8], i_calcNewPC[7:0]};
                    w_target_next = i_calcNewPC;
                end
            end
            ST_BR_FIX: begin
                o_calcJumpAbsolute    = 1'b1;
                o_calcAbsoluteAddress = r_target;
                w_pc_next             = i_calcNewPC;
                w_done_next           = 1'b1;
            end
            default: begin
                w_pc_next = r_pc;
            end
        endcase
    end

    // Datapath registers: PC, branch offset/target and the done pulse, all frozen by RDY low.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc          <= RESET_PC;
            r_offset      <= 8'h00;
            r_target      <= 16'h0000;
            r_branch_done <= 1'b0;
        end else if (i_ready) begin
            r_pc          <= w_pc_next;
            r_offset      <= w_offset_next;
            r_target      <= w_target_next;
            r_branch_done <= w_done_next;
        end else begin
            r_pc          <= r_pc;
            r_offset      <= r_offset;
            r_target      <= r_target;
            r_branch_done <= r_branch_done;
        end
    end

    assign o_pc         = r_pc;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_branchDone = r_branch_done;

endmodule

// File: doc/cpu6502_pc_sequencer.md
Name: cpu6502_pc_sequencer

Overview:
- Owns the 6502 program counter register and sequences every PC update through the jump calculator: increments, absolute jumps, and the multi-cycle relative-branch timing.
- Sits directly downstream of the decoder/control and drives the jump calculator's inputs (currentPC, increment, jumpRelative, jumpAbsolute, absoluteAddress, relativeOffset). It commits the calculator's newPC result and determines page crossing locally.
- Branch timing follows the NMOS 6502:
  - not taken: 2 cycles
  - taken, same page: 3 cycles
  - taken, page crossed: 4 cycles, with a dummy-read address {oldPCH, newPCL}

Parameters:
RESET_PC, 16'hFFFC, PC value loaded on reset

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
ready  in  1  RDY; low = hold all state, no commits
pcIncrement  in  1  advance PC by 1 (IDLE only)
jumpLoad  in  1  load jumpTarget into PC (IDLE only)
jumpTarget  in  16  absolute jump destination
branchStart  in  1  offset byte is at PC this cycle; branch condition valid
branchTaken  in  1  branch condition result, sampled with branchStart
branchOffset  in  8  signed relative offset, sampled with branchStart
calcNewPC  in  16  newPC from jump calculator
pc  out  16  registered PC; address bus and calculator currentPC
calcIncrement  out  1  to calculator increment
calcJumpRelative  out  1  to calculator jumpRelative
calcJumpAbsolute  out  1  to calculator jumpAbsolute
calcAbsoluteAddress  out  16  to calculator absoluteAddress
calcRelativeOffset  out  8  to calculator relativeOffset
busy  out  1  branch in progress (state != IDLE); decoder stalls
branchDone  out  1  one-cycle registered pulse, branch sequence complete

Behaviour:
- States: IDLE, BR_ADD, BR_FIX. Internal registers: offsetReg[7:0], targetReg[15:0].
- Reset (sync): pc=RESET_PC, state=IDLE, offsetReg=0, targetReg=0, branchDone=0. Reset wins over ready and all requests. A reset mid-branch aborts the branch without a branchDone pulse.
- All PC commits are pc<=calcNewPC, committed only when ready=1. When ready=0, pc, state, registers and branchDone hold. Calc outputs remain combinationally driven.
- IDLE, request priority:
  1. jumpLoad: calcJumpAbsolute=1, calcAbsoluteAddress=jumpTarget, commit.
  2. branchStart: calcIncrement=1, commit (PC moves past the offset byte), offsetReg<=branchOffset.
     - If branchTaken: go to BR_ADD.
     - Else: stay in IDLE and set branchDone=1 next cycle.
  3. pcIncrement: calcIncrement=1, commit.
  4. No request: all calc controls 0, pc holds.
- BR_ADD: calcJumpRelative=1, calcRelativeOffset=offsetReg. Target T=calcNewPC.
  - T[15:8]==pc[15:8]: pc<=T, go to IDLE, branchDone=1.
  - Otherwise: pc<={pc[15:8],T[7:0]} (dummy-read address), targetReg<=T, go to BR_FIX.
- BR_FIX: calcJumpAbsolute=1, calcAbsoluteAddress=targetReg, commit, go to IDLE, branchDone=1.
- busy is combinational (state!=IDLE). pcIncrement, jumpLoad and branchStart are ignored while busy.
- branchDone is high only in the cycle after the final commit; otherwise 0. It holds with ready=0.
- Only one calc control is asserted per cycle. When none is asserted, calcAbsoluteAddress=0 and calcRelativeOffset=0.
- Arithmetic is 16-bit modular: 0xFFFF+1 → 0x0000. A branch wrapping through 0xFFFF/0x0000 counts as a page crossing.
- Offset 0x00 taken: T==pc, no crossing, 3-cycle branch.
- Page crossing is decided solely by the high-byte compare. The calculator's own pageCrossing output is not used.
- The bench uses an ideal calculator model: newPC = currentPC + sign-extended offset / +1 / absolute.

Test Plan:
1. Reset → pc=0xFFFC, busy=0, branchDone=0; assert reset during BR_FIX → pc=0xFFFC, state IDLE, no branchDone.
2. pc=0x8000, pcIncrement for 3 cycles with ready low on cycle 2 → pc 0x8001, 0x8001, 0x8002. pc=0xFFFF + pcIncrement → 0x0000.
3. pc=0x80F0, branchStart, branchTaken=0, offset 0x10 → pc=0x80F1 next; busy never 1; branchDone the following cycle.
4. pc=0x8010, taken, offset 0x05 → pc 0x8011 (busy=1), then 0x8016 (busy=0, branchDone=1); calcJumpRelative=1 only in the BR_ADD cycle.
5. Page-crossing branches:
   - Forward: pc=0x80F0, offset 0x20 → pc 0x80F1, 0x8011 (dummy), 0x8111, then branchDone.
   - Backward: pc=0x8005, offset 0xF0 → 0x8006, 0x80F6, 0x7FF6.
   - Wrap: pc=0xFFF0, offset 0x20 → 0xFFF1, 0xFF11, 0x0011.
6. jumpLoad=1 (target 0x1234) with branchStart=1 and pcIncrement=1 in IDLE → pc=0x1234, state IDLE. jumpLoad while busy → ignored, branch completes normally.
